// File: rtl/hc4_rom_loader.sv
// HC4 program-memory loader: length-prefixed byte stream into a 2^ADDR_W x 8 memory, then registered fetch.
// Optional checksum byte after the data is enabled with `define HC4_LOADER_CSUM_EN.
module hc4_rom_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [7:0]        fetch_data,
  output logic              cpu_nReset,
  output logic              load_done,
  output logic              load_error
);

  // state   | meaning
  // IDLE    | after reset, waiting for load_req
  // LEN_HI  | expecting length high byte (upper nibble must be 0)
  // LEN_LO  | expecting length low byte
  // DATA    | writing image bytes
  // CSUM    | expecting checksum byte (feature builds only)
  // RUN     | image good, core released, fetches served
  // ERROR   | bad length or checksum, core held in reset
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERROR
  } state_t;

  localparam int HI_W = ADDR_W - 8;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [HI_W-1:0]   len_hi_q, len_hi_d;
  logic              rx_ready_q, cpu_nreset_q, load_done_q, load_error_q;
  logic [7:0]        fetch_data_q;
  logic              wr_en;
  logic              accept;
  logic [7:0]        mem_q [2**ADDR_W];
`ifdef HC4_LOADER_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    len_hi_d = len_hi_q;
    wr_en    = 1'b0;
`ifdef HC4_LOADER_CSUM_EN
    sum_d    = sum_q;
`endif
    // load_req wins over a byte offered in the same cycle
    if (load_req) begin
      state_d  = S_LEN_HI;
      addr_d   = '0;
      rem_d    = '0;
      len_hi_d = '0;
`ifdef HC4_LOADER_CSUM_EN
      sum_d    = 8'h00;
`endif
    end else if (accept) begin
      case (state_q)
        S_LEN_HI: begin
          if (rx_data[7:HI_W] != '0) begin
            state_d = S_ERROR;
          end else begin
            len_hi_d = rx_data[HI_W-1:0];
            state_d  = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          rem_d   = {len_hi_q, rx_data};
          addr_d  = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          wr_en  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
`ifdef HC4_LOADER_CSUM_EN
          sum_d  = sum_q + rx_data;
          if (rem_q == '0) state_d = S_CSUM;
`else
          if (rem_q == '0) state_d = S_RUN;
`endif
        end
`ifdef HC4_LOADER_CSUM_EN
        S_CSUM: state_d = ((sum_q + rx_data) == 8'h00) ? S_RUN : S_ERROR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      len_hi_q     <= '0;
      rx_ready_q   <= 1'b0;
      cpu_nreset_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef HC4_LOADER_CSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      len_hi_q     <= len_hi_d;
      // outputs decoded from next state so they switch with the state register
      rx_ready_q   <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      (state_d == S_DATA)   || (state_d == S_CSUM);
      cpu_nreset_q <= (state_d == S_RUN);
      load_done_q  <= (state_d == S_RUN);
      load_error_q <= (state_d == S_ERROR);
`ifdef HC4_LOADER_CSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // memory survives Reset and reloads
  always_ff @(posedge clk) begin
    if (wr_en && !Reset) mem_q[addr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (Reset)                 fetch_data_q <= 8'h00;
    else if (state_q == S_RUN) fetch_data_q <= mem_q[fetch_addr];
    else                       fetch_data_q <= 8'h00;
  end

  assign rx_ready   = rx_ready_q;
  assign cpu_nReset = cpu_nreset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign fetch_data = fetch_data_q;

endmodule
